// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the PMEM arbiter slice.
//   Holds the FSM state encoding, owner encoding, bus widths and the
//   latched request payload struct used by pmem_arbiter.
package pmem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// IFU/LSU request-response handshakes plus the memory-side port.
//   slave  : arbiter view (takes requests, drives responses and mem_*)
//   master : requester/memory-model view
interface pmem_arbiter_if;
  import pmem_arb_pkg::*;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/pmem_arb_pick.sv
// Combinational grant picker: one-hot grant indexed by owner encoding.
//   ifu_valid/lsu_valid : pending requests
//   fav_lsu             : on a conflict, 1 grants the LSU, 0 the IFU
//   grant[1:0]          : one-hot grant (bit OWN_IFU / bit OWN_LSU)
module pmem_arb_pick
  import pmem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       fav_lsu,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      if (fav_lsu) grant[OWN_LSU] = 1'b1;
      else         grant[OWN_IFU] = 1'b1;
    end else begin
      grant[OWN_IFU] = ifu_valid;
      grant[OWN_LSU] = lsu_valid;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one PMEM port between the IFU (read-only) and LSU (read/write).
// One transaction at a time: accept, wait LAT cycles, strobe the memory
// for exactly one cycle, then hold the response until the owner takes it.
//   clk, rst_n : clock, async active-low reset
//   bus        : pmem_arbiter_if.slave (IFU/LSU handshakes + mem_* port)
// Parameters: LAT (1..15) accept-to-strobe cycles, CNT_W counter width.
// Config macro: PMEM_ARB_RR_EN selects round-robin arbitration; when
// undefined the LSU has fixed priority over the IFU.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);
  localparam logic [1:0] ST_RESP = 2'(RESP);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  req_t              req_q, sel_req;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        grant;
  logic              fav_lsu;
  logic              accept;
  logic              fire;

  pmem_arb_pick u_pick (
    .ifu_valid (bus.ifu_req_valid),
    .lsu_valid (bus.lsu_req_valid),
    .fav_lsu   (fav_lsu),
    .grant     (grant)
  );

`ifdef PMEM_ARB_RR_EN
  // Conflict pointer: after a grant, favour the other requester.
  logic fav_lsu_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fav_lsu_q <= 1'b0;
    else if (accept) fav_lsu_q <= grant[OWN_IFU];
  end
  assign fav_lsu = fav_lsu_q;
`else
  assign fav_lsu = 1'b1;
`endif

  // Request payload of the winner; IFU write fields are forced to zero.
  always_comb begin
    sel_req = '0;
    if (grant[OWN_LSU]) begin
      sel_req.addr  = bus.lsu_addr;
      sel_req.wen   = bus.lsu_wen;
      sel_req.wdata = bus.lsu_wdata;
      sel_req.wmask = bus.lsu_wmask;
    end else begin
      sel_req.addr  = bus.ifu_addr;
    end
  end

  // Next state and decoded outputs.
  always_comb begin
    state_d            = state_q;
    accept             = 1'b0;
    fire               = 1'b0;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.mem_valid      = 1'b0;
    bus.mem_raddr      = '0;
    bus.mem_waddr      = '0;
    bus.mem_wen        = 1'b0;
    bus.mem_wdata      = '0;
    bus.mem_wmask      = '0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gating keeps ready low while reset is held.
        bus.ifu_req_ready = rst_n & grant[OWN_IFU];
        bus.lsu_req_ready = rst_n & grant[OWN_LSU];
        accept            = rst_n & (|grant);
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          fire          = 1'b1;
          bus.mem_valid = 1'b1;
          bus.mem_raddr = req_q.addr;
          bus.mem_waddr = req_q.addr;
          bus.mem_wen   = req_q.wen;
          bus.mem_wdata = req_q.wdata;
          bus.mem_wmask = req_q.wmask;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.ifu_resp_valid = (owner_q == OWN_IFU);
        bus.lsu_resp_valid = (owner_q == OWN_LSU);
        if ((owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request, latency counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IFU;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant[OWN_LSU];
        req_q   <= sel_req;
        cnt_q   <= CNT_W'(LAT - 1);
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q   <= cnt_q - 1'b1;
      end
      if (fire) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.ifu_rdata = rdata_q;
  assign bus.lsu_rdata = rdata_q;

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port arbiter and sequencer that shares the single physical-memory DPI port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the IFU/LSU request-response handshakes and the PMEM model. It accepts one transaction at a time, drives a single-cycle access strobe after a programmable latency, and returns the result to the owning requester. This gives the NPC a multi-cycle, bus-like memory timing in place of a combinational memory.

## Interface
- `LAT`, 1: cycles from request acceptance to the memory access strobe (legal 1..15).
- `CNT_W`, 4: latency counter width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_addr` in 32: IFU fetch request.
- `ifu_resp_valid` out 1 / `ifu_resp_ready` in 1 / `ifu_rdata` out 32: IFU response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_addr` in 32: LSU request handshake and address.
- `lsu_wen` in 1 / `lsu_wdata` in 32 / `lsu_wmask` in 8: LSU write controls.
- `lsu_resp_valid` out 1 / `lsu_resp_ready` in 1 / `lsu_rdata` out 32: LSU response.
- `mem_valid` out 1 / `mem_raddr` out 32 / `mem_rdata` in 32: memory-side read controls.
- `mem_wen` out 1 / `mem_waddr` out 32 / `mem_wdata` out 32 / `mem_wmask` out 8: memory-side write controls.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - The winner's `*_req_ready` = 1 combinationally; the loser's = 0.
  - On `valid && ready`: latch owner, addr, wen, wdata, wmask; load counter with `LAT-1`; go to WAIT.
- **WAIT**
  - Counter decrements each cycle.
  - In the cycle the counter is 0: `mem_valid`=1, `mem_raddr`=`mem_waddr`=latched addr, `mem_wen`=latched wen, data/mask driven from latches.
  - That same cycle: capture `mem_rdata` into the response register and go to RESP.
- **RESP**
  - The owner's `*_resp_valid`=1 and `*_rdata`=captured data, both held stable until `*_resp_ready`; then go to IDLE.
  - The non-owner's `resp_valid` stays 0.
- **Writes:** the LSU still receives a response, with `rdata` = the pre-write read value.
- **Idle outputs:** all `mem_*` outputs are 0 whenever `mem_valid`=0. `mem_valid` is high for exactly one cycle per transaction, so a write is never repeated.
- **IFU requests:** `wen`/`wdata`/`wmask` are forced to 0.
- **No requests in IDLE:** nothing happens.
- **Requests outside IDLE:** `req_ready` is 0; requesters hold their request.

## Timing
- Request accepted at edge T: `mem_valid` is high during cycle T+LAT; `resp_valid` rises after edge T+LAT+1.
- Minimum turnaround with `LAT`=1 and `resp_ready` tied high: 3 cycles per transaction.
- The next request may be accepted in the cycle after `resp_valid && resp_ready`.
- **Reset values:** state=IDLE, counter=0.
- **Outputs during reset:** all `req_ready`, `resp_valid` and `mem_*` = 0. `rdata` = 0.
- **Reset asserted mid-transaction:** the transaction is discarded; no `mem_valid` pulse and no response after release.
- **Simultaneous requests in IDLE:** resolved by the arbitration policy (see Configuration); exactly one is granted per cycle.

## Configuration
- Macro: `PMEM_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - A one-bit pointer favours the requester not granted last.
  - The pointer updates on each grant; its reset value favours the IFU.
- **Undefined:** fixed priority, LSU always beats IFU; no pointer flop exists.

## Structure
- Shared package `pmem_arb_pkg`:
  - state enum {IDLE, WAIT, RESP};
  - owner encoding (`OWN_IFU`=0, `OWN_LSU`=1);
  - `ADDR_W`=32, `DATA_W`=32, `MASK_W`=8.
- One sub-module, `pmem_arb_pick`: combinational grant logic taking both valids and the pointer, returning a one-hot grant. Swapping policy touches only this sub-module.

## Test plan
- IFU read only, `LAT`=1, addr 0x8000_0000, memory word 0x0000_0413 → one `mem_valid` pulse at T+1; `ifu_resp_valid` with `ifu_rdata`=0x0000_0413 at T+2; `lsu_resp_valid` stays 0.
- LSU write, addr 0x8000_0100, data 0xDEADBEEF, mask 0x0F → single `mem_valid` cycle with `mem_wen`=1; a subsequent IFU read of 0x8000_0100 returns 0xDEADBEEF.
- Both request every cycle, resp_ready=1:
  - without the macro, every grant goes to the LSU;
  - with `PMEM_ARB_RR_EN`, grants alternate IFU, LSU, IFU, … starting with the IFU.
- `LAT`=5 with `ifu_resp_ready` held low for 4 cycles after `resp_valid` → `mem_valid` at T+5; `rdata` stable while stalled; `req_ready` stays 0 until the handshake completes.
- `rst_n` pulsed low during WAIT of an LSU write → no `mem_valid` pulse; all outputs 0; FSM back in IDLE and accepts a new request the first cycle after release.
